// File: rtl/mmio_io_pkg.sv
// Shared constants for the MMIO I/O responder: register word offsets and STATUS bit layout.
package mmio_io_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_PORTIN = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   localparam int unsigned ST_FULL      = 0;
   localparam int unsigned ST_EMPTY     = 1;
   localparam int unsigned ST_COUNT_LSB = 2;
   localparam int unsigned ST_COUNT_W   = 5;
   localparam int unsigned ST_OVERFLOW  = 8;
   localparam int unsigned ST_CHANGE    = 9;

   localparam int unsigned CTRL_CLR_OVF = 0;
   localparam int unsigned CTRL_CLR_CHG = 1;

endpackage

// File: rtl/mmio_io_responder_sync_fifo.sv
// Synchronous FIFO with count; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_WIDTH-1:0]         wrData,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [DATA_WIDTH-1:0]         head
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wrPtr;
   logic [PW-1:0]         rdPtr;
   logic [CW-1:0]         cnt;
   logic                  doPush;
   logic                  doPop;

   assign empty  = (cnt == '0);
   assign full   = (cnt == CW'(FIFO_DEPTH));
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign count  = cnt;
   assign head   = mem[rdPtr];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         if (doPush && !doPop)      cnt <= cnt + 1'b1;
         else if (doPop && !doPush) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= wrData;
   end

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: TXDATA store FIFO, STATUS/PORTIN loads, CTRL sticky-flag clears.
// Optional PortIn change detect (STATUS bit9) is enabled by defining MMIO_PORTIN_CHANGE_EN.
module mmio_io_responder
   import mmio_io_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] BASE_ADDR  = 16'hFF00
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  Hit,
   input  logic [7:0]            PortIn,
   output logic [DATA_WIDTH-1:0] PortOut,
   output logic                  PortOutValid,
   input  logic                  PortOutReady
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]            wordSel;
   logic                  wrTx;
   logic                  wrCtrl;
   logic                  popReq;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] head;
   logic                  overflow;
   logic                  changeFlag;
   logic [7:0]            syncMeta;
   logic [7:0]            syncPin;
   logic [DATA_WIDTH-1:0] status;
   logic                  unusedAddr;

   assign Hit        = (Address[15:4] == BASE_ADDR[15:4]);
   assign wordSel    = Address[3:2];
   assign unusedAddr = ^Address[1:0];
   assign wrTx       = MemWrite && Hit && (wordSel == OFF_TXDATA);
   assign wrCtrl     = MemWrite && Hit && (wordSel == OFF_CTRL);

   assign PortOutValid = !empty;
   assign popReq       = PortOutReady;
   assign PortOut      = PortOutValid ? head : '0;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) outFifo (
      .clk    (clk),
      .reset  (reset),
      .push   (wrTx),
      .pop    (popReq),
      .wrData (WriteData),
      .full   (full),
      .empty  (empty),
      .count  (count),
      .head   (head)
   );

   // A push into a full FIFO is only dropped when no pop frees a slot that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (wrTx && full && !(PortOutReady && !empty)) begin
         overflow <= 1'b1;
      end else if (wrCtrl && WriteData[CTRL_CLR_OVF]) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         syncMeta <= '0;
         syncPin  <= '0;
      end else begin
         syncMeta <= PortIn;
         syncPin  <= syncMeta;
      end
   end

`ifdef MMIO_PORTIN_CHANGE_EN
   logic [7:0] prevPin;

   always_ff @(posedge clk) begin
      if (reset) begin
         prevPin    <= '0;
         changeFlag <= 1'b0;
      end else begin
         prevPin <= syncPin;
         if (syncPin != prevPin)
            changeFlag <= 1'b1;
         else if (wrCtrl && WriteData[CTRL_CLR_CHG])
            changeFlag <= 1'b0;
      end
   end
`else
   assign changeFlag = 1'b0;
`endif

   always_comb begin
      status                          = '0;
      status[ST_FULL]                 = full;
      status[ST_EMPTY]                = empty;
      status[ST_COUNT_LSB +: CW]      = count;
      status[ST_OVERFLOW]             = overflow;
      status[ST_CHANGE]               = changeFlag;
   end

   always_comb begin
      ReadData = '0;
      if (MemRead && Hit) begin
         case (wordSel)
            OFF_STATUS: ReadData = status;
            OFF_PORTIN: ReadData = DATA_WIDTH'(syncPin);
            default:    ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for mmio_io_responder: directed scenarios followed by random bus traffic.
module tb_mmio_io_responder;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic        PortOutValid;
   logic        PortOutReady;

   mmio_io_responder #(
      .DATA_WIDTH (32),
      .FIFO_DEPTH (DEPTH),
      .BASE_ADDR  (16'hFF00)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .Address      (Address),
      .WriteData    (WriteData),
      .MemWrite     (MemWrite),
      .MemRead      (MemRead),
      .ReadData     (ReadData),
      .Hit          (Hit),
      .PortIn       (PortIn),
      .PortOut      (PortOut),
      .PortOutValid (PortOutValid),
      .PortOutReady (PortOutReady)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        hit;
      logic        valid;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] txQ[$];

   // Reference model state
   logic [31:0] mQ[$];
   bit          mOvf;
   bit          mChg;
   logic [7:0]  mS1;
   logic [7:0]  mVis;
   logic [7:0]  mVisPrev;
   bit          modelValid = 0;

   int unsigned passCnt = 0;
   int unsigned totalCnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else
         passCnt++;
   endtask

   function automatic logic [31:0] modelRead(input logic [15:0] a, input logic re);
      logic [31:0] v;
      logic [1:0]  sel;
      int unsigned n;
      v   = '0;
      sel = a[3:2];
      n   = mQ.size();
      if (re && a[15:4] == 12'hFF0) begin
         if (sel == 2'd1) begin
            v = (n == DEPTH ? 32'h1 : 32'h0) | (n == 0 ? 32'h2 : 32'h0) | (n << 2)
              | (mOvf ? 32'h100 : 32'h0) | (mChg ? 32'h200 : 32'h0);
         end else if (sel == 2'd2) begin
            v = {24'h0, mVis};
         end
      end
      return v;
   endfunction

   // Advance the model by one clock edge with the inputs that were held during that cycle.
   task automatic modelEdge(input logic r, input logic [15:0] a, input logic [31:0] wd,
                            input logic we, input logic rdy, input logic [7:0] pin);
      bit          hit;
      bit          popNow;
      bit          chgSet;
      int unsigned nBefore;
      if (r) begin
         mQ.delete();
         txQ.delete();
         mOvf = 0; mChg = 0; mS1 = '0; mVis = '0; mVisPrev = '0;
         modelValid = 1;
         return;
      end
      hit     = (a[15:4] == 12'hFF0);
      nBefore = mQ.size();
      popNow  = (nBefore > 0) && rdy;
      chgSet  = (mVis != mVisPrev);
      if (popNow) void'(mQ.pop_front());
      if (we && hit && a[3:2] == 2'd0) begin
         if (nBefore < DEPTH || popNow) begin
            mQ.push_back(wd);
            txQ.push_back(wd);
         end else begin
            mOvf = 1;
         end
      end
      if (we && hit && a[3:2] == 2'd3) begin
         if (wd[0]) mOvf = 0;
`ifdef MMIO_PORTIN_CHANGE_EN
         if (wd[1]) mChg = 0;
`endif
      end
`ifdef MMIO_PORTIN_CHANGE_EN
      if (chgSet) mChg = 1;
`endif
      mVisPrev = mVis;
      mVis     = mS1;
      mS1      = pin;
   endtask

   // Called just after a rising edge: apply inputs, record expectations, run one edge.
   task automatic step(input logic r, input logic [15:0] a, input logic [31:0] wd,
                       input logic we, input logic re, input logic rdy, input logic [7:0] pin);
      exp_t e;
      reset = r; Address = a; WriteData = wd; MemWrite = we; MemRead = re;
      PortOutReady = rdy; PortIn = pin;
      if (modelValid) begin
         e.rd    = modelRead(a, re);
         e.hit   = (a[15:4] == 12'hFF0);
         e.valid = (mQ.size() > 0);
         expQ.push_back(e);
      end
      @(posedge clk);
      modelEdge(r, a, wd, we, rdy, pin);
      #1;
   endtask

   // Monitor: compares combinational outputs and the output stream mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         chk("ReadData", ReadData, e.rd);
         chk("Hit", {31'h0, Hit}, {31'h0, e.hit});
         chk("PortOutValid", {31'h0, PortOutValid}, {31'h0, e.valid});
         if (!PortOutValid) begin
            chk("PortOutIdle", PortOut, 32'h0);
         end else if (txQ.size() == 0) begin
            chk("PortOutUnexpected", PortOut, 32'hxxxx_xxxx);
         end else if (PortOutReady && !reset) begin
            chk("PortOutXfer", PortOut, txQ.pop_front());
         end else begin
            chk("PortOutHold", PortOut, txQ[0]);
         end
      end
   end

   logic [7:0] pinVal = '0;

   initial begin
      logic [15:0] a;
      logic [31:0] wd;
      logic        we, re, rdy, r;
      // Reset state
      step(1, 16'hFF04, 0, 0, 0, 0, pinVal);
      step(1, 16'hFF04, 0, 0, 0, 0, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      // Single push
      step(0, 16'hFF00, 32'hA5A5_0001, 1, 0, 0, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      // Overflow on the fifth push, then drain and clear
      step(1, 16'h0000, 0, 0, 0, 0, pinVal);
      for (int i = 1; i <= 5; i++) step(0, 16'hFF00, i, 1, 0, 0, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      for (int i = 0; i < 6; i++) step(0, 16'hFF04, 0, 0, 1, 1, pinVal);
      step(0, 16'hFF0C, 32'h1, 1, 0, 0, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      // Push into full FIFO together with a pop
      for (int i = 0; i < 4; i++) step(0, 16'hFF00, 32'h10 + i, 1, 0, 0, pinVal);
      step(0, 16'hFF00, 32'h77, 1, 1, 1, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      for (int i = 0; i < 6; i++) step(0, 16'hFF04, 0, 0, 1, 1, pinVal);
      // PortIn synchronizer and change flag
      pinVal = 8'h3C;
      for (int i = 0; i < 4; i++) step(0, 16'hFF08, 0, 0, 1, 0, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      step(0, 16'hFF0C, 32'h2, 1, 1, 0, pinVal);
      step(0, 16'hFF04, 0, 0, 1, 0, pinVal);
      // Outside the window, plus store/load to read-only offsets
      step(0, 16'h1000, 0, 0, 1, 0, pinVal);
      step(0, 16'h1004, 32'hFFFF_FFFF, 1, 1, 0, pinVal);
      step(0, 16'h1000, 32'h1234_5678, 1, 0, 0, pinVal);
      step(0, 16'hFF04, 32'hFFFF_FFFF, 1, 1, 0, pinVal);
      step(0, 16'hFF08, 32'hFFFF_FFFF, 1, 1, 0, pinVal);
      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0)
            a = 16'($urandom);
         else
            a = 16'hFF00 | 16'($urandom_range(0, 15));
         wd  = $urandom;
         if (a[3:2] == 2'd3 && $urandom_range(0, 3) != 0) wd = wd & 32'h3;
         we  = ($urandom_range(0, 9) < 4);
         re  = ($urandom_range(0, 1) == 1);
         rdy = ($urandom_range(0, 9) < 4);
         r   = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) pinVal = 8'($urandom);
         step(r, a, wd, we, re, rdy, pinVal);
      end
      step(0, 16'h0000, 0, 0, 0, 0, pinVal);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
